// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
// Definitions shared by the UART transmitter and receiver: the 2-bit frame
// FSM state encoding, the minimum legal bit period and the frame geometry.
// ---------------------------------------------------------------------------
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Bit periods below this are promoted to it; one-cycle bits would leave
    // the receiver no mid-bit sampling point.
    localparam int MIN_CPD   = 2;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_timer.sv
// ---------------------------------------------------------------------------
// uart_baud_timer
// Bit-period timer. An up-counter that runs from 0 to period-1 and wraps,
// flagging the last cycle of each period on bit_tick. The owner holds clear
// whenever the line is idle so the first period starts from a known phase.
//
// Ports
//   clk       in   1          system clock, rising edge
//   resetn    in   1          asynchronous active-low reset
//   clear     in   1          force the count back to zero next cycle
//   period    in   CPD_WIDTH  cycles per bit (caller guarantees >= 2)
//   bit_tick  out  1          high on the last cycle of each period
// ---------------------------------------------------------------------------
module uart_baud_timer #(
    parameter int CPD_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic [CPD_WIDTH-1:0] period,
    output logic                 bit_tick
);

    logic [CPD_WIDTH-1:0] cnt_q;
    logic [CPD_WIDTH-1:0] cnt_d;

    always_comb begin
        bit_tick = (cnt_q == (period - CPD_WIDTH'(1)));
        cnt_d    = cnt_q + CPD_WIDTH'(1);
        // Wrapping at the terminal count means the counter can never run
        // past period-1, so no overflow handling is needed.
        if (clear || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter, 8 data bits, no parity, STOP_BITS stop bits, LSB first,
// idle-high line. A one-byte holding register lets the next byte be queued
// while the current frame shifts out; a queued byte follows the previous
// stop bit with no idle gap. The bit period is sampled at each frame start.
//
// Ports
//   clk                 in   1          system clock, rising edge
//   resetn              in   1          asynchronous active-low reset
//   cycles_per_databit  in   CPD_WIDTH  clock cycles per bit (0/1 act as 2)
//   tx_data             in   8          byte to send
//   tx_load             in   1          write strobe, taken when tx_ready=1
//   tx_ready            out  1          holding register empty
//   tx_line             out  1          serial output (registered)
//   tx_busy             out  1          a frame is on the line
//   tx_done             out  1          pulse on the last cycle of a frame
//
// State     | Meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | line high, timer held clear, waiting for a queued byte
// ST_START  | start bit (line low) for one bit period
// ST_DATA   | eight data bits, LSB first, one bit period each
// ST_STOP   | STOP_BITS stop bits (line high); chain or return to idle
// ---------------------------------------------------------------------------
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CPD_WIDTH = 10,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [CPD_WIDTH-1:0] cycles_per_databit,
    input  logic [7:0]           tx_data,
    input  logic                 tx_load,
    output logic                 tx_ready,
    output logic                 tx_line,
    output logic                 tx_busy,
    output logic                 tx_done
);

    uart_state_e          state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [2:0]           idx_q, idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [CPD_WIDTH-1:0] period_q, period_d;
    logic                 line_q, line_d;

    logic                 bit_tick;
    logic                 timer_clear;
    logic                 drain;
    logic                 done;
    logic                 stop_last;
    logic [CPD_WIDTH-1:0] period_eff;

    assign period_eff = (cycles_per_databit < CPD_WIDTH'(MIN_CPD))
                        ? CPD_WIDTH'(MIN_CPD) : cycles_per_databit;

    // With a single stop bit the first stop period is already the last one.
    assign stop_last  = (STOP_BITS < 2) || stop_idx_q;

    assign tx_ready   = ~hold_full_q;
    assign tx_busy    = (state_q != ST_IDLE);
    assign tx_line    = line_q;
    assign tx_done    = done;

    uart_baud_timer #(
        .CPD_WIDTH (CPD_WIDTH)
    ) u_baud_timer (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (timer_clear),
        .period   (period_q),
        .bit_tick (bit_tick)
    );

    // line_d is the value the line takes in the next state, so the line flop
    // and the state flop change on the same edge.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        idx_d       = idx_q;
        stop_idx_d  = stop_idx_q;
        period_d    = period_q;
        line_d      = line_q;
        timer_clear = 1'b0;
        drain       = 1'b0;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_clear = 1'b1;
                line_d      = 1'b1;
                if (hold_full_q) begin
                    drain    = 1'b1;
                    shift_d  = hold_q;
                    period_d = period_eff;
                    state_d  = ST_START;
                    line_d   = 1'b0;
                end
            end

            ST_START: begin
                if (bit_tick) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                    line_d  = shift_q[0];
                end
            end

            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'(DATA_BITS - 1)) begin
                        state_d    = ST_STOP;
                        stop_idx_d = 1'b0;
                        line_d     = 1'b1;
                    end else begin
                        line_d     = shift_q[1];
                    end
                end
            end

            ST_STOP: begin
                if (bit_tick) begin
                    if (stop_last) begin
                        done        = 1'b1;
                        timer_clear = 1'b1;
                        if (hold_full_q) begin
                            drain    = 1'b1;
                            shift_d  = hold_q;
                            period_d = period_eff;
                            state_d  = ST_START;
                            line_d   = 1'b0;
                        end else begin
                            state_d  = ST_IDLE;
                            line_d   = 1'b1;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                line_d  = 1'b1;
            end
        endcase

        // An accepted load wins over a drain in the same cycle: the old byte
        // has already moved to the shift register and the new one is kept.
        if (tx_load && tx_ready) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end else if (drain) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            idx_q       <= '0;
            stop_idx_q  <= 1'b0;
            period_q    <= CPD_WIDTH'(MIN_CPD);
            line_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            idx_q       <= idx_d;
            stop_idx_q  <= stop_idx_d;
            period_q    <= period_d;
            line_q      <= line_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int CPD_W = 10;
    localparam int STOP  = 1;

    logic             clk    = 1'b0;
    logic             clk_en = 1'b0;
    logic             resetn = 1'b1;
    logic [CPD_W-1:0] cpd    = '0;
    logic [7:0]       tx_data = '0;
    logic             tx_load = 1'b0;
    logic             tx_ready;
    logic             tx_line;
    logic             tx_busy;
    logic             tx_done;

    int errors = 0;
    int checks = 0;

    uart_tx #(
        .CPD_WIDTH (CPD_W),
        .STOP_BITS (STOP)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .cycles_per_databit (cpd),
        .tx_data            (tx_data),
        .tx_load            (tx_load),
        .tx_ready           (tx_ready),
        .tx_line            (tx_line),
        .tx_busy            (tx_busy),
        .tx_done            (tx_done)
    );

    always #5 if (clk_en) clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int eff_p(input int c);
        return (c < 2) ? 2 : c;
    endfunction

    // Line level at cycle c (0 = first start-bit cycle) of a frame.
    function automatic logic exp_line(input logic [7:0] b, input int p, input int c);
        int k;
        k = c / p;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    // Called at a negedge. Waits up to max_wait cycles for a frame to begin,
    // then compares every cycle of consecutive frames against the model and
    // finally checks that the line returns to idle.
    task automatic check_stream(input logic [7:0] data[$], input int per[$],
                                input int max_wait, input string tag);
        int waited;
        waited = 0;
        while (tx_busy !== 1'b1 && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (tx_busy !== 1'b1 || tx_line !== 1'b0) begin
            errors++;
            $display("FAIL %s start: busy=%b line=%b after %0d cycles, required busy=1 line=0",
                     tag, tx_busy, tx_line, waited);
            return;
        end
        foreach (data[f]) begin
            int len;
            len = (9 + STOP) * per[f];
            for (int c = 0; c < len; c++) begin
                logic el, ed;
                el = exp_line(data[f], per[f], c);
                ed = (c == len - 1);
                checks++;
                if (tx_line !== el || tx_busy !== 1'b1 || tx_done !== ed) begin
                    errors++;
                    $display("FAIL %s frame%0d cyc%0d: line=%b busy=%b done=%b, required line=%b busy=1 done=%b",
                             tag, f, c, tx_line, tx_busy, tx_done, el, ed);
                end
                @(negedge clk);
            end
        end
        checks++;
        if (tx_busy !== 1'b0 || tx_line !== 1'b1 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: busy=%b line=%b done=%b, required 0 1 0",
                     tag, tx_busy, tx_line, tx_done);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 resetn = 1'b0;
        #2;
        checks++;
        if (tx_line !== 1'b1) begin errors++; $display("FAIL reset_line: got %b required 1", tx_line); end
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", tx_ready); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", tx_busy); end
        checks++;
        if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", tx_done); end
        clk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_line !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: line=%b ready=%b busy=%b required 1 1 0",
                     tx_line, tx_ready, tx_busy);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] d[$];
        int p[$];
        cpd = 16;
        d.push_back(8'hA5);
        p.push_back(16);
        @(negedge clk);
        tx_data = 8'hA5;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        checks++;
        if (tx_ready !== 1'b0 || tx_line !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_n1: ready=%b line=%b busy=%b required 0 1 0", tx_ready, tx_line, tx_busy);
        end
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_after_drain: got %b required 1", tx_ready);
        end
        check_stream(d, p, 0, "single_a5");
    endtask

    task automatic test_back_to_back();
        logic [7:0] d[$];
        int p[$];
        cpd = 4;
        d.push_back(8'h00); d.push_back(8'hFF);
        p.push_back(4);     p.push_back(4);
        @(negedge clk);
        tx_data = 8'h00;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        checks++;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop1: got %b required 0", tx_ready); end
        @(negedge clk);
        fork
            check_stream(d, p, 0, "b2b");
            begin
                repeat (5) @(negedge clk);
                checks++;
                if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_before2: got %b required 1", tx_ready); end
                tx_data = 8'hFF;
                tx_load = 1'b1;
                @(negedge clk);
                tx_load = 1'b0;
                checks++;
                if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop2: got %b required 0", tx_ready); end
                repeat (33) @(negedge clk);
                checks++;
                if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_held: got %b required 0", tx_ready); end
                @(negedge clk);
                checks++;
                if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_recover: got %b required 1", tx_ready); end
            end
        join
    endtask

    task automatic test_overrun();
        logic [7:0] d[$];
        int p[$];
        cpd = 4;
        d.push_back(8'h5A); d.push_back(8'hC3);
        p.push_back(4);     p.push_back(4);
        @(negedge clk);
        tx_data = 8'h5A;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        @(negedge clk);
        fork
            begin
                check_stream(d, p, 0, "overrun");
                for (int i = 0; i < 12; i++) begin
                    checks++;
                    if (tx_busy !== 1'b0 || tx_line !== 1'b1) begin
                        errors++;
                        $display("FAIL overrun_no_third_frame cyc%0d: busy=%b line=%b required 0 1",
                                 i, tx_busy, tx_line);
                    end
                    @(negedge clk);
                end
            end
            begin
                repeat (2) @(negedge clk);
                tx_data = 8'hC3;
                tx_load = 1'b1;
                @(negedge clk);
                checks++;
                if (tx_ready !== 1'b0) begin errors++; $display("FAIL overrun_full: ready=%b required 0", tx_ready); end
                tx_data = 8'h99;
                @(negedge clk);
                tx_load = 1'b0;
            end
        join
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d[$];
        int p[$];
        cpd = 8;
        @(negedge clk);
        tx_data = 8'h00;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        @(negedge clk);
        repeat (35) @(negedge clk);
        checks++;
        if (tx_line !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: line=%b busy=%b required 0 1", tx_line, tx_busy);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (tx_line !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: line=%b busy=%b ready=%b done=%b required 1 0 1 0",
                     tx_line, tx_busy, tx_ready, tx_done);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        d.push_back(8'h3C);
        p.push_back(8);
        tx_data = 8'h3C;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        @(negedge clk);
        check_stream(d, p, 0, "rstmid_3c");
    endtask

    task automatic test_cpd_change();
        logic [7:0] d1[$];
        logic [7:0] d2[$];
        int p1[$];
        int p2[$];
        cpd = 1;
        d1.push_back(8'h96);
        p1.push_back(2);
        @(negedge clk);
        tx_data = 8'h96;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        check_stream(d1, p1, 4, "cpd1");

        cpd = 8;
        d2.push_back(8'h4B); d2.push_back(8'hE1);
        p2.push_back(8);     p2.push_back(20);
        @(negedge clk);
        tx_data = 8'h4B;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        @(negedge clk);
        fork
            check_stream(d2, p2, 0, "cpd_change");
            begin
                repeat (20) @(negedge clk);
                cpd = 20;
                tx_data = 8'hE1;
                tx_load = 1'b1;
                @(negedge clk);
                tx_load = 1'b0;
            end
        join
    endtask

    // Independent mid-bit sampling receiver with random periods; the period
    // input is scrambled once each frame has started.
    task automatic test_random_loopback();
        for (int i = 0; i < 6; i++) begin
            int c0, p, w;
            logic [7:0] b, got;
            c0 = $urandom_range(0, 12);
            p = eff_p(c0);
            b = 8'($urandom);
            got = '0;
            cpd = CPD_W'(c0);
            @(negedge clk);
            tx_data = b;
            tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
            w = 0;
            while (tx_line !== 1'b0 && w < 10) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (tx_line !== 1'b0) begin
                errors++;
                $display("FAIL loop%0d start: no start bit within 10 cycles, line=%b", i, tx_line);
                continue;
            end
            cpd = CPD_W'($urandom_range(0, 12));
            repeat (p / 2) @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                repeat (p) @(negedge clk);
                got[j] = tx_line;
            end
            repeat (p) @(negedge clk);
            checks++;
            if (tx_line !== 1'b1) begin
                errors++;
                $display("FAIL loop%0d stop: line=%b required 1 (p=%0d)", i, tx_line, p);
            end
            checks++;
            if (got !== b) begin
                errors++;
                $display("FAIL loop%0d byte: received %h required %h (p=%0d)", i, got, b, p);
            end
            w = 0;
            while (tx_busy !== 1'b0 && w < 3 * p + 5) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (tx_busy !== 1'b0) begin
                errors++;
                $display("FAIL loop%0d end: busy=%b required 0", i, tx_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
        test_cpd_change();
        test_random_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
